complex_mult_rs: RTL and testbench
==================================

// Module: complex_mult_rs
// PURPOSE
//  Parametrised pipelined complex multiplier: p = a*b, or a*conj(b) when conj_b=1.
//  Output is rounded, shifted and saturated to OUT_W bits, with a per-sample saturation flag.
//  Strobe/valid travels with the data through a 4-stage pipeline; enable stalls the whole pipe.
//  Serves the RX chain (CFO rotation, channel-estimate correction, autocorrelation) where a*conj(b) is needed.
// PARAMETERS
//  IN_W   16  signed width of each input I/Q component
//  OUT_W  16  signed width of each output I/Q component
//  SHIFT  15  arithmetic right shift applied to the full-precision sum (0..2*IN_W)
// PORTS
//  clock          in   1      rising-edge clock
//  rstn           in   1      asynchronous active-low reset
//  enable         in   1      pipeline clock-enable; 0 freezes all stages (data and strobes)
//  conj_b         in   1      1: multiply by conj(b); sampled with input_strobe, travels with the sample
//  a_i, a_q       in   IN_W   operand a, signed two's complement
//  b_i, b_q       in   IN_W   operand b, signed two's complement
//  input_strobe   in   1      operands valid this cycle (only when enable=1)
//  p_i, p_q       out  OUT_W  rounded, saturated product, signed
//  sat            out  1      1 if p_i or p_q was clipped for this sample
//  output_strobe  out  1      p_i/p_q/sat valid this cycle
// BEHAVIOUR
//  - Reset (rstn=0, async): every pipeline register, valid bit, p_i, p_q, sat and output_strobe go to 0.
//  - Stage 1: register a, b, conj_b and valid (valid = input_strobe).
//  - Stage 2: four signed products ar*br, ai*bi, ai*br, ar*bi, each 2*IN_W bits.
//  - Stage 3, sums at 2*IN_W+1 bits (sign-extend, no wrap):
//      conj_b=0: I = ar*br - ai*bi ; Q = ai*br + ar*bi
//      conj_b=1: I = ar*br + ai*bi ; Q = ai*br - ar*bi
//  - Stage 4, per component:
//      SHIFT>0: add 2^(SHIFT-1), then arithmetic >> SHIFT (round half toward +inf). SHIFT=0: no rounding.
//      Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat = OR of both component clips.
//  - Latency: output_strobe rises exactly 4 enabled cycles after the input_strobe cycle.
//    Throughput is 1 sample per enabled cycle; back-to-back strobes are legal.
//  - Stage registers load only when enable=1. With enable=0, outputs and valids hold their values;
//    output_strobe stays at its current level (the consumer must qualify it with enable).
//  - Data registers load regardless of the valid bit. Outputs with output_strobe=0 are don't-care
//    but must be deterministic: the registers hold, and no X may appear after reset.
//  - input_strobe with enable=0 is ignored (the sample is dropped).
//  - Reset asserted mid-stream flushes all in-flight samples; no output_strobe until new input.
//  - The worst case -2^(IN_W-1) squared twice must not overflow stage 3 (hence 2*IN_W+1 bits).
// TESTING (defaults IN_W=16, OUT_W=16, SHIFT=15; enable=1 unless stated)
//  1. a=(16384,0), b=(16384,0), conj_b=0 -> p=(8192,0), sat=0, output_strobe exactly 4 cycles later.
//  2. a=(16384,16384), b=(16384,-16384): conj_b=0 -> p=(16384,0); conj_b=1 -> p=(0,16384).
//  3. Rounding: a=(1,0), b=(16384,0) -> p_i=1; b=(16383,0) -> p_i=0; a=(-1,0), b=(16384,0) -> p_i=0.
//  4. Saturation: a=b=(-32768,-32768), conj_b=1 -> I=2^31 -> p_i=32767, p_q=0, sat=1;
//     conj_b=0 -> p=(0,32767), sat=1.
//  5. Stream of 8 back-to-back samples with enable=0 for 3 cycles mid-stream -> all 8 outputs
//     correct and in order; output_strobe frozen during the stall; total latency 4+3 cycles.
//  6. rstn pulsed low 2 cycles after 3 strobes issued -> outputs/strobe 0 immediately;
//     no stale output_strobe afterwards.

Source files
------------

// File: rtl/complex_mult_rs.sv
// Pipelined complex multiplier p = a*b or a*conj(b), with rounding, shift and saturation.
// Four register stages carry data, conj select and valid; enable stalls every stage together.
module complex_mult_rs #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enable,
  input  logic                    conj_b,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  a_q,
  input  logic signed [IN_W-1:0]  b_i,
  input  logic signed [IN_W-1:0]  b_q,
  input  logic                    input_strobe,
  output logic signed [OUT_W-1:0] p_i,
  output logic signed [OUT_W-1:0] p_q,
  output logic                    sat,
  output logic                    output_strobe
);

  localparam int PW = 2 * IN_W;
  localparam int SW = PW + 1;
  localparam int RW = SW + 1;
  localparam int RNDPOS = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? RW'(64'sd1 <<< RNDPOS) : '0;
  localparam logic signed [RW-1:0] MAXV = RW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] MINV = RW'(-(64'sd1 <<< (OUT_W - 1)));

  // Stage 1: operand capture
  logic signed [IN_W-1:0] ar_q, ai_q, br_q, bi_q;
  logic                   conj1_q, v1_q;

  // Stage 2: partial products
  logic signed [PW-1:0] prr_d, pii_d, pir_d, pri_d;
  logic signed [PW-1:0] prr_q, pii_q, pir_q, pri_q;
  logic                 conj2_q, v2_q;

  // Stage 3: full-precision sums
  logic signed [SW-1:0] sumI_d, sumQ_d;
  logic signed [SW-1:0] sumI_q, sumQ_q;
  logic                 v3_q;

  // Stage 4: rounded, saturated result
  logic signed [OUT_W-1:0] p_i_d, p_q_d, p_i_q, p_q_q;
  logic                    sat_d, sat_q, vout_q;

  // Returns {clip, value}: round half toward +inf, arithmetic shift, clamp to OUT_W.
  function automatic logic [OUT_W:0] roundSat(input logic signed [SW-1:0] s);
    logic signed [RW-1:0] r;
    logic                 clip;
    logic [OUT_W-1:0]     val;
    r = RW'(s) + RND;
    r = r >>> SHIFT;
    clip = 1'b0;
    val  = r[OUT_W-1:0];
    if (r > MAXV) begin
      clip = 1'b1;
      val  = MAXV[OUT_W-1:0];
    end else if (r < MINV) begin
      clip = 1'b1;
      val  = MINV[OUT_W-1:0];
    end
    return {clip, val};
  endfunction

  always_comb begin
    prr_d = PW'(ar_q) * PW'(br_q);
    pii_d = PW'(ai_q) * PW'(bi_q);
    pir_d = PW'(ai_q) * PW'(br_q);
    pri_d = PW'(ar_q) * PW'(bi_q);
  end

  // One extra bit keeps (-2^(IN_W-1))^2 + (-2^(IN_W-1))^2 from wrapping.
  always_comb begin
    if (conj2_q) begin
      sumI_d = SW'(prr_q) + SW'(pii_q);
      sumQ_d = SW'(pir_q) - SW'(pri_q);
    end else begin
      sumI_d = SW'(prr_q) - SW'(pii_q);
      sumQ_d = SW'(pir_q) + SW'(pri_q);
    end
  end

  always_comb begin
    logic [OUT_W:0] rsI, rsQ;
    rsI   = roundSat(sumI_q);
    rsQ   = roundSat(sumQ_q);
    p_i_d = rsI[OUT_W-1:0];
    p_q_d = rsQ[OUT_W-1:0];
    sat_d = rsI[OUT_W] | rsQ[OUT_W];
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      ar_q    <= '0;
      ai_q    <= '0;
      br_q    <= '0;
      bi_q    <= '0;
      conj1_q <= 1'b0;
      v1_q    <= 1'b0;
      prr_q   <= '0;
      pii_q   <= '0;
      pir_q   <= '0;
      pri_q   <= '0;
      conj2_q <= 1'b0;
      v2_q    <= 1'b0;
      sumI_q  <= '0;
      sumQ_q  <= '0;
      v3_q    <= 1'b0;
      p_i_q   <= '0;
      p_q_q   <= '0;
      sat_q   <= 1'b0;
      vout_q  <= 1'b0;
    end else if (enable) begin
      ar_q    <= a_i;
      ai_q    <= a_q;
      br_q    <= b_i;
      bi_q    <= b_q;
      conj1_q <= conj_b;
      v1_q    <= input_strobe;
      prr_q   <= prr_d;
      pii_q   <= pii_d;
      pir_q   <= pir_d;
      pri_q   <= pri_d;
      conj2_q <= conj1_q;
      v2_q    <= v1_q;
      sumI_q  <= sumI_d;
      sumQ_q  <= sumQ_d;
      v3_q    <= v2_q;
      p_i_q   <= p_i_d;
      p_q_q   <= p_q_d;
      sat_q   <= sat_d;
      vout_q  <= v3_q;
    end
  end

  assign p_i           = p_i_q;
  assign p_q           = p_q_q;
  assign sat           = sat_q;
  assign output_strobe = vout_q;

endmodule

// File: tb/tb_complex_mult_rs.sv
// Directed testbench for complex_mult_rs: vector table, stalled stream, and mid-stream reset.
module tb_complex_mult_rs;

  logic               clock = 1'b0;
  logic               rstn;
  logic               enable;
  logic               conj_b;
  logic signed [15:0] a_i, a_q, b_i, b_q;
  logic               input_strobe;
  logic signed [15:0] p_i, p_q;
  logic               sat;
  logic               output_strobe;

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    int    ai, aq, bi, bq;
    bit    conj;
    int    expPi, expPq;
    bit    expSat;
    string name;
  } vecT;

  vecT vecs[8];
  vecT stream[8];

  complex_mult_rs #(.IN_W(16), .OUT_W(16), .SHIFT(15)) dut (
    .clock(clock), .rstn(rstn), .enable(enable), .conj_b(conj_b),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .input_strobe(input_strobe),
    .p_i(p_i), .p_q(p_q), .sat(sat), .output_strobe(output_strobe)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one sample at the falling edge so it is captured at the next rising edge.
  task automatic applyStimulus(input vecT v, input bit strobe);
    a_i          = 16'(v.ai);
    a_q          = 16'(v.aq);
    b_i          = 16'(v.bi);
    b_q          = 16'(v.bq);
    conj_b       = v.conj;
    input_strobe = strobe;
  endtask

  // Reference arithmetic in 64-bit integers, floor shift after half-LSB bias.
  function automatic void model(inout vecT v);
    longint re, im, ri, rq;
    if (v.conj) begin
      re = longint'(v.ai) * v.bi + longint'(v.aq) * v.bq;
      im = longint'(v.aq) * v.bi - longint'(v.ai) * v.bq;
    end else begin
      re = longint'(v.ai) * v.bi - longint'(v.aq) * v.bq;
      im = longint'(v.aq) * v.bi + longint'(v.ai) * v.bq;
    end
    ri = (re + 16384) >>> 15;
    rq = (im + 16384) >>> 15;
    v.expSat = 1'b0;
    if (ri > 32767)  begin ri = 32767;  v.expSat = 1'b1; end
    if (ri < -32768) begin ri = -32768; v.expSat = 1'b1; end
    if (rq > 32767)  begin rq = 32767;  v.expSat = 1'b1; end
    if (rq < -32768) begin rq = -32768; v.expSat = 1'b1; end
    v.expPi = int'(ri);
    v.expPq = int'(rq);
  endfunction

  initial begin
    vecT idle;
    int  lat, got, sent, strobes;

    vecs[0] = '{16384, 0, 16384, 0, 1'b0, 8192, 0, 1'b0, "unit"};
    vecs[1] = '{16384, 16384, 16384, -16384, 1'b0, 16384, 0, 1'b0, "mulPlain"};
    vecs[2] = '{16384, 16384, 16384, -16384, 1'b1, 0, 16384, 1'b0, "mulConj"};
    vecs[3] = '{1, 0, 16384, 0, 1'b0, 1, 0, 1'b0, "roundHalfUp"};
    vecs[4] = '{1, 0, 16383, 0, 1'b0, 0, 0, 1'b0, "roundBelowHalf"};
    vecs[5] = '{-1, 0, 16384, 0, 1'b0, 0, 0, 1'b0, "roundNegHalf"};
    vecs[6] = '{-32768, -32768, -32768, -32768, 1'b1, 32767, 0, 1'b1, "satConj"};
    vecs[7] = '{-32768, -32768, -32768, -32768, 1'b0, 0, 32767, 1'b1, "satPlain"};

    stream[0] = '{1000, -2000, 3000, 4000, 1'b0, 0, 0, 1'b0, "s0"};
    stream[1] = '{-32768, -32768, -32768, -32768, 1'b1, 0, 0, 1'b0, "s1"};
    stream[2] = '{12345, -6789, -23456, 111, 1'b0, 0, 0, 1'b0, "s2"};
    stream[3] = '{32767, 32767, 32767, 32767, 1'b0, 0, 0, 1'b0, "s3"};
    stream[4] = '{-5, 7, 9, -11, 1'b1, 0, 0, 1'b0, "s4"};
    stream[5] = '{20000, 20000, -20000, 20000, 1'b1, 0, 0, 1'b0, "s5"};
    stream[6] = '{-1, 0, 16384, 0, 1'b0, 0, 0, 1'b0, "s6"};
    stream[7] = '{16384, 16384, 16384, -16384, 1'b1, 0, 0, 1'b0, "s7"};
    foreach (stream[k]) model(stream[k]);

    idle = '{0, 0, 0, 0, 1'b0, 0, 0, 1'b0, "idle"};

    rstn   = 1'b0;
    enable = 1'b1;
    applyStimulus(idle, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("resetPi", p_i, 0);
    checkOutput("resetPq", p_q, 0);
    checkOutput("resetSat", sat, 0);
    checkOutput("resetStrobe", output_strobe, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clock);

    // Table vectors, one at a time, with latency measured in falling edges.
    foreach (vecs[k]) begin
      @(negedge clock);
      applyStimulus(vecs[k], 1'b1);
      lat = 0;
      for (int c = 1; c <= 10; c++) begin
        @(negedge clock);
        if (c == 1) input_strobe = 1'b0;
        if (output_strobe) begin
          lat = c;
          break;
        end
      end
      checkOutput({vecs[k].name, "_latency"}, lat, 4);
      checkOutput({vecs[k].name, "_pi"}, p_i, vecs[k].expPi);
      checkOutput({vecs[k].name, "_pq"}, p_q, vecs[k].expPq);
      checkOutput({vecs[k].name, "_sat"}, sat, int'(vecs[k].expSat));
    end

    // Back-to-back stream with a three-cycle stall while sample 1 sits at the output.
    got  = 0;
    sent = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      if (cyc >= 6 && cyc <= 8) begin
        checkOutput("stallStrobe", output_strobe, 1);
        checkOutput("stallPi", p_i, stream[1].expPi);
      end
      enable = !(cyc >= 5 && cyc <= 7);
      if (output_strobe && enable) begin
        if (got < 8) begin
          checkOutput({stream[got].name, "_cycle"}, cyc, (got == 0) ? 4 : got + 7);
          checkOutput({stream[got].name, "_pi"}, p_i, stream[got].expPi);
          checkOutput({stream[got].name, "_pq"}, p_q, stream[got].expPq);
          checkOutput({stream[got].name, "_sat"}, sat, int'(stream[got].expSat));
        end
        got++;
      end
      if (enable && sent < 8) begin
        applyStimulus(stream[sent], 1'b1);
        sent++;
      end else begin
        applyStimulus(idle, 1'b0);
      end
    end
    enable = 1'b1;
    checkOutput("streamCount", got, 8);

    // Reset while three samples are in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      applyStimulus(vecs[0], 1'b1);
    end
    @(negedge clock);
    applyStimulus(idle, 1'b0);
    @(negedge clock);
    checkOutput("preResetStrobe", output_strobe, 1);
    rstn = 1'b0;
    #1;
    checkOutput("midResetPi", p_i, 0);
    checkOutput("midResetPq", p_q, 0);
    checkOutput("midResetStrobe", output_strobe, 0);
    @(negedge clock);
    rstn = 1'b1;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (output_strobe) strobes++;
    end
    checkOutput("staleStrobes", strobes, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
